mem_access_unit: RTL and testbench

Clocked load/store initiator that drives the processor's combinational, word-addressed data RAM on behalf of the CPU pipeline. It accepts one byte-addressed request at a time (LB/LBU/LH/LHU/LW/SB/SH/SW) and checks alignment and range. It sequences the RAM port, using read-modify-write for sub-word stores, and returns aligned, extended load data through a valid/ready response handshake. It sits between the execute/memory stage and the RAM's `dataIn`/`address`/`writeEnable`/`dataOut` port.

---
 rtl/mem_access_pkg.sv | 21 ++
 rtl/mem_load_align.sv | 21 ++
 rtl/mem_access_unit.sv | 108 ++++++++++
 tb/tb_mem_access_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, FSM states and byte-lane mask helper
// shared by the memory access unit and its load aligner.
package mem_access_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } state_t;

   function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
      return (size == SIZE_B ? 32'h0000_00FF : size == SIZE_H ? 32'h0000_FFFF : 32'hFFFF_FFFF)
             << {lane, 3'b000};
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: extracts a byte/half/word lane from a RAM word and
// sign- or zero-extends it to 32 bits.
module mem_load_align
   import mem_access_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = 8'(i_word >> {i_lane, 3'b000});
   assign w_half = 16'(i_word >> {i_lane, 3'b000});
   assign o_data = i_size == SIZE_B ? {{24{w_byte[7] & ~i_unsigned}}, w_byte} :
                   i_size == SIZE_H ? {{16{w_half[15] & ~i_unsigned}}, w_half} : i_word;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store initiator for a combinational
// word-addressed RAM; sub-word stores are done as read-modify-write.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int Height = 256,
   parameter int Length = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      reqValid,
   output logic                      reqReady,
   input  logic                      reqWrite,
   input  logic [1:0]                reqSize,
   input  logic                      reqUnsigned,
   input  logic [31:0]               reqAddr,
   input  logic [Length-1:0]         reqWData,
   output logic                      respValid,
   input  logic                      respReady,
   output logic [Length-1:0]         respData,
   output logic                      respError,
   output logic [$clog2(Height)-1:0] ramAddress,
   output logic [Length-1:0]         ramWData,
   output logic                      ramWriteEnable,
   input  logic [Length-1:0]         ramRData
);

   localparam int AW = $clog2(Height);

   state_t            r_state;
   state_t            w_next;
   logic              r_write;
   logic              r_uns;
   logic              r_err;
   logic [1:0]        r_size;
   logic [1:0]        r_lane;
   logic [AW-1:0]     r_index;
   logic [31:0]       r_wdata;
   logic [31:0]       r_resp_data;
   logic              w_accept;
   logic              w_err;
   logic [31:0]       w_load;
   logic [31:0]       w_mask;
   logic [31:0]       w_merged;

   assign w_err = (&reqSize) || (reqSize == SIZE_H && reqAddr[0]) ||
                  (reqSize == SIZE_W && |reqAddr[1:0]) || (|reqAddr[31:AW+2]);
   assign w_accept = reqValid && reqReady;
   assign w_mask = lane_mask(r_size, r_lane);
   assign w_merged = (ramRData & ~w_mask) | ((r_wdata << {r_lane, 3'b000}) & w_mask);

   mem_load_align u_align (
      .i_word     (ramRData),
      .i_lane     (r_lane),
      .i_size     (r_size),
      .i_unsigned (r_uns),
      .o_data     (w_load)
   );

   // r_wdata doubles as the write word: raw data for SW, merged word after READ
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_write     <= 1'b0;
         r_uns       <= 1'b0;
         r_err       <= 1'b0;
         r_size      <= SIZE_B;
         r_lane      <= 2'd0;
         r_index     <= '0;
         r_wdata     <= '0;
         r_resp_data <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_write     <= reqWrite;
            r_uns       <= reqUnsigned;
            r_err       <= w_err;
            r_size      <= reqSize;
            r_lane      <= reqAddr[1:0];
            r_index     <= reqAddr[AW+1:2];
            r_wdata     <= reqWData;
            r_resp_data <= '0;
         end
         if (r_state == ST_READ && r_write) r_wdata <= w_merged;
         if (r_state == ST_READ && !r_write) r_resp_data <= w_load;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (reqValid) w_next = w_err ? ST_RESP : (reqWrite && reqSize == SIZE_W) ? ST_WRITE : ST_READ;
         ST_READ:  w_next = r_write ? ST_WRITE : ST_RESP;
         ST_WRITE: w_next = ST_RESP;
         ST_RESP:  if (respReady) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   assign reqReady       = r_state == ST_IDLE;
   assign respValid      = r_state == ST_RESP;
   assign respData       = respValid ? r_resp_data : '0;
   assign respError      = respValid && r_err;
   assign ramAddress     = r_state == ST_IDLE ? '0 : r_index;
   assign ramWriteEnable = r_state == ST_WRITE;
   assign ramWData       = ramWriteEnable ? r_wdata : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plan cases plus randomized requests, checked
// against a byte-level reference model of the RAM and request rules.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        reqValid = 1'b0;
   logic        reqReady;
   logic        reqWrite = 1'b0;
   logic [1:0]  reqSize = 2'd0;
   logic        reqUnsigned = 1'b0;
   logic [31:0] reqAddr = '0;
   logic [31:0] reqWData = '0;
   logic        respValid;
   logic        respReady = 1'b0;
   logic [31:0] respData;
   logic        respError;
   logic [7:0]  ramAddress;
   logic [31:0] ramWData;
   logic        ramWriteEnable;
   logic [31:0] ramRData;

   logic [31:0] ram [256];
   logic [31:0] mm  [256];
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.Height(256), .Length(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
      .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddr(reqAddr), .reqWData(reqWData),
      .respValid(respValid), .respReady(respReady), .respData(respData), .respError(respError),
      .ramAddress(ramAddress), .ramWData(ramWData), .ramWriteEnable(ramWriteEnable),
      .ramRData(ramRData)
   );

   assign ramRData = ram[ramAddress];
   always @(posedge clk) if (ramWriteEnable) ram[ramAddress] = ramWData;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: byte-wise view of the request against the model memory
   task automatic model(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] d, output logic err, output logic [31:0] rdata,
                        output logic [31:0] nword, output int lat, output int strobes);
      int idx, l, nb;
      logic [31:0] v;
      idx = int'(a[9:2]);
      l = int'(a[1:0]);
      nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
      err = sz == 2'd3 || (nb == 2 && l % 2 != 0) || (nb == 4 && l != 0) || (a >= 32'd1024);
      rdata = '0;
      nword = mm[idx];
      lat = 1;
      strobes = 0;
      if (!err && !w) begin
         v = '0;
         for (int k = 0; k < nb; k++) v[8*k +: 8] = mm[idx][8*(l+k) +: 8];
         if (!u && v[8*nb-1]) for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
         rdata = v;
         lat = 2;
      end else if (!err) begin
         for (int k = 0; k < nb; k++) nword[8*(l+k) +: 8] = d[8*k +: 8];
         strobes = 1;
         lat = nb == 4 ? 2 : 3;
      end
   endtask

   task automatic xact(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] d, input int stall);
      logic e;
      logic [31:0] er, nw;
      int el, es, lat, strobes;
      model(w, sz, u, a, d, e, er, nw, el, es);
      @(negedge clk);
      chk("req_ready", reqReady, 1);
      reqValid = 1'b1; reqWrite = w; reqSize = sz; reqUnsigned = u; reqAddr = a; reqWData = d;
      respReady = 1'b0;
      lat = 0;
      strobes = 0;
      do begin
         @(posedge clk);
         #1;
         reqValid = 1'b0;
         lat++;
         if (ramWriteEnable) begin
            strobes++;
            chk("ram_wdata", ramWData, nw);
            chk("ram_addr", 32'(ramAddress), 32'(a[9:2]));
         end
      end while (!respValid && lat < 8);
      chk("latency", lat, el);
      chk("resp_data", respData, er);
      chk("resp_error", respError, e);
      repeat (stall) begin
         @(negedge clk);
         chk("stall_valid", respValid, 1);
         chk("stall_data", respData, er);
         chk("stall_ready", reqReady, 0);
      end
      @(negedge clk);
      respReady = 1'b1;
      @(posedge clk);
      #1;
      respReady = 1'b0;
      chk("strobes", strobes, es);
      chk("idle_ready", reqReady, 1);
      chk("idle_valid", respValid, 0);
      if (!e && w) mm[a[9:2]] = nw;
      chk("ram_word", ram[a[9:2]], mm[a[9:2]]);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, reqReady, 1);
      chk({tag, "_resp_valid"}, respValid, 0);
      chk({tag, "_resp_data"}, respData, 0);
      chk({tag, "_resp_error"}, respError, 0);
      chk({tag, "_ram_addr"}, 32'(ramAddress), 0);
      chk({tag, "_ram_wdata"}, ramWData, 0);
      chk({tag, "_ram_we"}, ramWriteEnable, 0);
   endtask

   initial begin
      logic [31:0] a;
      for (int i = 0; i < 256; i++) begin
         ram[i] = $urandom;
         mm[i] = ram[i];
      end
      ram[5] = 32'h8040_20F0;
      mm[5] = 32'h8040_20F0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      xact(1'b0, 2'd0, 1'b0, 32'h15, 0, 0);
      chk("lb_0x15_const", respData, 32'h0);
      xact(1'b0, 2'd0, 1'b0, 32'h17, 0, 0);
      xact(1'b0, 2'd0, 1'b1, 32'h17, 0, 0);
      xact(1'b0, 2'd1, 1'b1, 32'h16, 0, 0);
      xact(1'b0, 2'd1, 1'b0, 32'h16, 0, 0);
      xact(1'b0, 2'd2, 1'b0, 32'h14, 0, 0);
      xact(1'b1, 2'd0, 1'b0, 32'h16, 32'h0000_00AB, 0);
      chk("sb_result", ram[5], 32'h80AB_20F0);
      xact(1'b0, 2'd2, 1'b0, 32'h14, 0, 0);
      xact(1'b1, 2'd2, 1'b0, 32'h14, 32'h1234_5678, 0);
      chk("sw_result", ram[5], 32'h1234_5678);
      xact(1'b0, 2'd2, 1'b0, 32'h16, 0, 0);
      xact(1'b0, 2'd2, 1'b0, 32'h400, 0, 0);
      xact(1'b0, 2'd3, 1'b0, 32'h14, 0, 0);
      xact(1'b0, 2'd2, 1'b0, 32'h14, 0, 4);
      xact(1'b1, 2'd1, 1'b0, 32'h16, 32'hBEEF_CAFE, 0);

      // Reset while a sub-word store is in its READ cycle
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd0; reqUnsigned = 1'b0;
      reqAddr = 32'h16; reqWData = 32'h55;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      chk("mid_read_addr", 32'(ramAddress), 5);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid_reset");
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("mid_reset_no_we", ramWriteEnable, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_reset_ram5", ram[5], mm[5]);

      for (int i = 0; i < 80; i++) begin
         a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(10, 31));
         xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              a, $urandom, $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
